// File: rtl/mel_pkg.sv
// mel_pkg: shared constants, types and filter tables for the mel filterbank.
//   NFFT_C / NUM_FILTERS_C : frame size and filter count.
//   BIN_SEG[k]             : segment s of bin k; bin k lies between mel
//                            points s and s+1 (SEG_NONE = outside all filters).
//   BIN_WUP[k]             : Q0.16 rising-slope weight of bin k for filter s.
//                            Filter s-1 receives 16'hFFFF - BIN_WUP[k].
// Mel points follow m(s) = s*(s+8)/8: roughly linear at low bins and
// widening with s. They are strictly increasing, so every segment owns at
// least one bin. Bins at or above m(NUM_FILTERS_C+1) are outside all filters.
package mel_pkg;
  localparam int NFFT_C        = 257;
  localparam int NUM_FILTERS_C = 40;
  localparam int ADDR_W        = $clog2(NFFT_C) + 1;
  localparam int BIN_W         = $clog2(NFFT_C);
  localparam logic [6:0] SEG_NONE = 7'd127;

  typedef logic [55:0] acc_t;
  typedef logic [8:0]  energy_t;
  typedef logic [NFFT_C-1:0][6:0]  seg_tab_t;
  typedef logic [NFFT_C-1:0][15:0] wup_tab_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } mel_state_e;

  function automatic int mel_point(input int s);
    return (s * (s + 8)) / 8;
  endfunction

  function automatic seg_tab_t build_seg();
    seg_tab_t t;
    for (int k = 0; k < NFFT_C; k++) t[k] = SEG_NONE;
    for (int s = 0; s <= NUM_FILTERS_C; s++)
      for (int k = mel_point(s); k < mel_point(s + 1) && k < NFFT_C; k++)
        t[k] = 7'(s);
    return t;
  endfunction

  function automatic wup_tab_t build_wup();
    wup_tab_t t;
    int m0;
    int m1;
    for (int k = 0; k < NFFT_C; k++) t[k] = 16'd0;
    for (int s = 0; s <= NUM_FILTERS_C; s++) begin
      m0 = mel_point(s);
      m1 = mel_point(s + 1);
      for (int k = m0; k < m1 && k < NFFT_C; k++)
        t[k] = 16'(((k - m0) * 65536) / (m1 - m0));
    end
    return t;
  endfunction

  localparam seg_tab_t BIN_SEG = build_seg();
  localparam wup_tab_t BIN_WUP = build_wup();
endpackage

// File: rtl/mel_log2.sv
// mel_log2: combinational log encoder.
//   x_i [39:0] : integer energy (accumulator >> 16).
//   e_o [8:0]  : {msb index (6 bits), 3 bits just below the msb}; 0 for x_i == 0.
// For msb index < 3 the mantissa is left-aligned and zero-filled.
module mel_log2 (
  input  logic [39:0] x_i,
  output logic [8:0]  e_o
);
  logic [5:0]  msb;
  logic [42:0] shifted;

  always_comb begin
    msb = 6'd0;
    // Ascending scan: the highest set bit is the last one to write msb.
    for (int i = 0; i < 40; i++) begin
      if (x_i[i]) msb = 6'(i);
    end
    // Appending three zeros and shifting right by msb leaves the three bits
    // below the msb in [2:0], zero-filled when msb < 3.
    shifted = {x_i, 3'b000} >> msb;
    e_o     = (x_i == 40'd0) ? 9'd0 : {msb, shifted[2:0]};
  end
endmodule

// File: rtl/mel.sv
// mel: triangular mel filterbank over one power-spectrum frame.
//   clk, rst_n                   : clock, asynchronous active-low reset.
//   mel_start_i                  : one-cycle start pulse, accepted in IDLE only.
//   prt_power_spectrum_frame     : bin read address (0 while idle).
//   value_power_spectrum_frame   : bin power, returned 1 cycle after the address.
//   mel_valid / mel_prt_energies / mel_value_energies : one strobe per filter,
//                                  index and log energy valid with the strobe.
//   mel_done_o                   : one-cycle pulse, one cycle after the last strobe.
//   dbg_state_o                  : current FSM state.
// Protocol: there is no back-pressure. Strobes are single-cycle and must be
// captured when mel_valid is high, and the memory must answer every address
// one cycle later.
//
// cur_seg_q is the segment the accumulators describe: acc_dn_q holds filter
// cur_seg_q-1 and acc_up_q holds filter cur_seg_q. An "advance" emits acc_dn_q
// as filter cur_seg_q-1, shifts acc_up_q down and increments cur_seg_q. A bin
// more than one segment ahead is replayed: it is re-fetched after one advance
// so that only one filter is emitted per cycle. Bins outside every filter are
// held at segment NUM_FILTERS_C, so that the last filter is always emitted in
// FLUSH, directly before done.
module mel
  import mel_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mel_start_i,
  output logic [ADDR_W-1:0] prt_power_spectrum_frame,
  input  logic [31:0]       value_power_spectrum_frame,
  output logic              mel_done_o,
  output logic [8:0]        mel_value_energies,
  output logic [5:0]        mel_prt_energies,
  output logic              mel_valid,
  output logic [1:0]        dbg_state_o
);
  mel_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              issue_q;
  logic              rd_valid_q;
  logic [BIN_W-1:0]  rd_bin_q;
  logic [6:0]        cur_seg_q;
  acc_t              acc_up_q, acc_dn_q;
  acc_t              acc_up_d, acc_dn_d;
  logic              done_q, valid_q;
  logic [5:0]        idx_q;
  energy_t           val_q;

  logic [6:0]  seg_in, eff_seg;
  logic [15:0] wup_in;
  logic [47:0] prod_up, prod_dn;
  logic        in_filter, do_adv, do_acc, do_replay, emit_v;
  energy_t     log_out;

  assign seg_in    = BIN_SEG[rd_bin_q];
  assign wup_in    = BIN_WUP[rd_bin_q];
  assign in_filter = (seg_in != SEG_NONE);
  assign eff_seg   = (seg_in > 7'(NUM_FILTERS_C)) ? 7'(NUM_FILTERS_C) : seg_in;
  assign prod_up   = 48'(value_power_spectrum_frame) * 48'(wup_in);
  assign prod_dn   = 48'(value_power_spectrum_frame) * 48'(16'hFFFF - wup_in);

  always_comb begin
    do_adv    = 1'b0;
    do_acc    = 1'b0;
    do_replay = 1'b0;
    if (state_q == ST_FETCH && rd_valid_q) begin
      if (eff_seg == cur_seg_q) begin
        do_acc = in_filter;
      end else if (eff_seg == cur_seg_q + 7'd1) begin
        do_adv = 1'b1;
        do_acc = in_filter;
      end else if (eff_seg > cur_seg_q) begin
        do_adv    = 1'b1;
        do_replay = 1'b1;
      end
    end else if (state_q == ST_FLUSH && cur_seg_q <= 7'(NUM_FILTERS_C)) begin
      do_adv = 1'b1;
    end
    emit_v = do_adv && (cur_seg_q != 7'd0) && (cur_seg_q <= 7'(NUM_FILTERS_C));

    acc_up_d = do_adv ? 56'd0 : acc_up_q;
    acc_dn_d = do_adv ? acc_up_q : acc_dn_q;
    if (do_acc) begin
      acc_up_d = acc_up_d + 56'(prod_up);
      acc_dn_d = acc_dn_d + 56'(prod_dn);
    end
  end

  mel_log2 u_log2 (
    .x_i (acc_dn_q[55:16]),
    .e_o (log_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      issue_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_bin_q   <= '0;
      cur_seg_q  <= '0;
      acc_up_q   <= '0;
      acc_dn_q   <= '0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      val_q      <= '0;
    end else begin
      valid_q    <= emit_v;
      idx_q      <= emit_v ? 6'(cur_seg_q - 7'd1) : 6'd0;
      val_q      <= emit_v ? log_out : 9'd0;
      acc_up_q   <= acc_up_d;
      acc_dn_q   <= acc_dn_d;
      if (do_adv) cur_seg_q <= cur_seg_q + 7'd1;
      // A replay discards the read that is already in flight.
      rd_valid_q <= issue_q && !do_replay;
      rd_bin_q   <= addr_q[BIN_W-1:0];
      done_q     <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          addr_q    <= '0;
          issue_q   <= 1'b0;
          cur_seg_q <= '0;
          acc_up_q  <= '0;
          acc_dn_q  <= '0;
          if (mel_start_i) begin
            state_q <= ST_FETCH;
            issue_q <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (do_replay) begin
            addr_q  <= {1'b0, rd_bin_q};
            issue_q <= 1'b1;
          end else if (issue_q) begin
            if (addr_q == ADDR_W'(NFFT_C - 1)) begin
              addr_q  <= '0;
              issue_q <= 1'b0;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
          if (rd_valid_q && !do_replay && rd_bin_q == BIN_W'(NFFT_C - 1))
            state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (cur_seg_q == 7'(NUM_FILTERS_C + 1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign prt_power_spectrum_frame = addr_q;
  assign mel_done_o               = done_q;
  assign mel_valid                = valid_q;
  assign mel_prt_energies         = idx_q;
  assign mel_value_energies       = val_q;
  assign dbg_state_o              = state_q;
endmodule

// File: tb/tb_mel.sv
// tb_mel: directed bench for the mel filterbank and its log encoder.
module tb_mel;
  import mel_pkg::*;

  localparam int FRAME_BUDGET = NFFT_C + NUM_FILTERS_C + 40;
  localparam int LAT_BOUND    = NFFT_C + NUM_FILTERS_C + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT ----------------
  logic              mel_start_i = 1'b0;
  logic [ADDR_W-1:0] prt_power_spectrum_frame;
  logic [31:0]       value_power_spectrum_frame = 32'd0;
  logic              mel_done_o;
  logic [8:0]        mel_value_energies;
  logic [5:0]        mel_prt_energies;
  logic              mel_valid;
  logic [1:0]        dbg_state_o;

  mel dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .mel_start_i                (mel_start_i),
    .prt_power_spectrum_frame   (prt_power_spectrum_frame),
    .value_power_spectrum_frame (value_power_spectrum_frame),
    .mel_done_o                 (mel_done_o),
    .mel_value_energies         (mel_value_energies),
    .mel_prt_energies           (mel_prt_energies),
    .mel_valid                  (mel_valid),
    .dbg_state_o                (dbg_state_o)
  );

  logic [39:0] lx = 40'd0;
  logic [8:0]  le;
  mel_log2 u_log_ut (.x_i(lx), .e_o(le));

  // ---------------- spectrum memory (1-cycle read) ----------------
  logic [31:0] mem [NFFT_C];
  always @(posedge clk)
    value_power_spectrum_frame <= (prt_power_spectrum_frame < ADDR_W'(NFFT_C)) ?
                                  mem[prt_power_spectrum_frame[BIN_W-1:0]] : 32'd0;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  logic [5:0] got_idx[$];
  logic [8:0] got_val[$];
  int done_cnt = 0;
  int both_cnt = 0;
  int done_cyc = 0;
  int last_valid_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mel_valid) begin
        got_idx.push_back(mel_prt_energies);
        got_val.push_back(mel_value_energies);
        last_valid_cyc = cyc;
      end
      if (mel_done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (mel_valid && mel_done_o) both_cnt++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- golden model ----------------
  function automatic logic [8:0] log_model(input logic [63:0] acc);
    logic [63:0] x;
    int p;
    logic [63:0] m;
    x = acc >> 16;
    if (x == 64'd0) return 9'd0;
    p = 0;
    for (int i = 0; i < 40; i++) if ((x >> i) != 64'd0) p = i;
    if (p >= 3) m = (x >> (p - 3)) & 64'd7;
    else        m = (x << (3 - p)) & 64'd7;
    return {6'(p), m[2:0]};
  endfunction

  task automatic build_exp();
    logic [63:0] sum;
    exp_q.delete();
    for (int f = 0; f < NUM_FILTERS_C; f++) begin
      sum = 64'd0;
      for (int k = 0; k < NFFT_C; k++) begin
        if (int'(BIN_SEG[k]) == f)
          sum += 64'(mem[k]) * 64'(BIN_WUP[k]);
        if (int'(BIN_SEG[k]) == f + 1)
          sum += 64'(mem[k]) * 64'(16'hFFFF - BIN_WUP[k]);
      end
      exp_q.push_back(log_model(sum));
    end
  endtask

  task automatic fill_mem(input int mode);
    for (int k = 0; k < NFFT_C; k++) begin
      case (mode)
        0:       mem[k] = 32'd0;
        1:       mem[k] = 32'hFFFF_FFFF;
        default: mem[k] = 32'(k) * 32'h9E37_79B1 + 32'd17;
      endcase
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(posedge clk); #1 mel_start_i = 1'b1;
    @(posedge clk); #1 mel_start_i = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int mode, input bit extra_start);
    int start_cyc;
    bit seen;
    int mx;
    fill_mem(mode);
    build_exp();
    got_idx.delete();
    got_val.delete();
    done_cnt = 0;
    both_cnt = 0;
    @(posedge clk); #1 mel_start_i = 1'b1; start_cyc = cyc;
    @(posedge clk); #1 mel_start_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < FRAME_BUDGET && !seen; i++) begin
      @(negedge clk);
      mel_start_i = (extra_start && i == 60);
      if (done_cnt != 0) seen = 1'b1;
    end
    mel_start_i = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    repeat (4) @(negedge clk);
    check({tag, "_idle_after"}, 64'(dbg_state_o), 64'd0);
    check({tag, "_valid_count"}, 64'(got_idx.size()), 64'(NUM_FILTERS_C));
    check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    check({tag, "_done_after_last"}, 64'(done_cyc), 64'(last_valid_cyc + 1));
    check({tag, "_no_valid_with_done"}, 64'(both_cnt), 64'd0);
    check({tag, "_latency"}, 64'(done_cyc - start_cyc <= LAT_BOUND), 64'd1);
    mx = 0;
    for (int f = 0; f < NUM_FILTERS_C && f < got_idx.size(); f++) begin
      check($sformatf("%s_idx%0d", tag, f), 64'(got_idx[f]), 64'(f));
      check($sformatf("%s_val%0d", tag, f), 64'(got_val[f]), 64'(exp_q[f]));
      if (int'(got_val[f]) > mx) mx = int'(got_val[f]);
    end
    check({tag, "_max_le_319"}, 64'(mx <= 319), 64'd1);
  endtask

  // ---------------- log encoder vectors ----------------
  typedef struct {
    logic [39:0] x;
    logic [8:0]  e;
  } log_vec_t;
  log_vec_t lv[9];

  initial begin
    lv[0] = '{40'd0, 9'd0};
    lv[1] = '{40'd1, 9'd0};
    lv[2] = '{40'd3, 9'd12};
    lv[3] = '{40'd5, 9'd18};
    lv[4] = '{40'd8, 9'd24};
    lv[5] = '{40'd12, 9'd28};
    lv[6] = '{40'h1F, 9'd39};
    lv[7] = '{40'h80_0000_0000, 9'd312};
    lv[8] = '{40'hFF_FFFF_FFFF, 9'd319};

    fill_mem(0);

    // Reset and idle.
    #2 rst_n = 1'b0;
    #1;
    check("rst_addr", 64'(prt_power_spectrum_frame), 64'd0);
    check("rst_valid", 64'(mel_valid), 64'd0);
    check("rst_done", 64'(mel_done_o), 64'd0);
    check("rst_energy", 64'(mel_value_energies), 64'd0);
    check("rst_index", 64'(mel_prt_energies), 64'd0);
    check("rst_state", 64'(dbg_state_o), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("idle_addr_c%0d", i), 64'(prt_power_spectrum_frame), 64'd0);
    end
    check("idle_no_valid", 64'(got_idx.size()), 64'd0);

    // Log encoder table.
    for (int i = 0; i < 9; i++) begin
      lx = lv[i].x;
      #1;
      check($sformatf("log2_x%0d", i), 64'(le), 64'(lv[i].e));
    end

    // Frames: zero, saturated, then zero again 5 cycles after done.
    run_frame("zero", 0, 1'b0);
    run_frame("ones", 1, 1'b0);
    run_frame("zero_b2b", 0, 1'b0);
    // Pattern frame with a second start mid-frame.
    run_frame("pat_midstart", 2, 1'b1);

    // Reset mid-frame.
    fill_mem(1);
    pulse_start();
    repeat (100) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_addr", 64'(prt_power_spectrum_frame), 64'd0);
    check("midrst_valid", 64'(mel_valid), 64'd0);
    check("midrst_energy", 64'(mel_value_energies), 64'd0);
    check("midrst_state", 64'(dbg_state_o), 64'd0);
    got_idx.delete();
    got_val.delete();
    done_cnt = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (NFFT_C + 60) @(negedge clk);
    check("midrst_no_done", 64'(done_cnt), 64'd0);
    check("midrst_no_valid", 64'(got_idx.size()), 64'd0);

    run_frame("after_rst", 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mel.md
Name: mel

Overview:
- Mel filterbank stage of the MFCC core. On a start pulse it streams one power-spectrum frame of NFFT bins from an external synchronous memory. It applies NUM_FILTERS overlapping triangular mel filters and emits one 9-bit log-compressed energy per filter, in ascending filter order.
- Sits between the power-spectrum stage and the DCT stage.

Parameters:
- NUM_FILTERS, 40, number of triangular mel filters (must be ≤ 64).
- NFFT, 257, number of power-spectrum bins per frame (512-point FFT, positive half).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mel_start_i  in  1  one-cycle pulse that starts a frame. Ignored while busy.
- prt_power_spectrum_frame  out  $clog2(NFFT)+1 (10)  bin read address to spectrum memory.
- value_power_spectrum_frame  in  32  unsigned bin power; valid 1 cycle after the address is presented.
- mel_done_o  out  1  one-cycle pulse; frame complete.
- mel_value_energies  out  9  log energy of filter mel_prt_energies.
- mel_prt_energies  out  6  filter index of current energy.
- mel_valid  out  1  energy/index valid this cycle.

Behaviour:
- Reset (async): all outputs 0, FSM in IDLE, accumulators 0.
- FSM states and transitions:
  - IDLE: start → FETCH.
  - FETCH: issue addresses 0..NFFT-1, one per cycle.
  - Accumulate: pipelined with FETCH, runs on data returning 1 cycle later.
  - FLUSH: emit remaining filters.
  - DONE: mel_done_o=1 for one cycle, then back to IDLE.
- Address is held at 0 when idle.
- Filter shape comes from package tables, one entry per bin k:
  - BIN_SEG[k] (7 bits): segment s, meaning bin k lies between mel points s and s+1. Value 127 = outside all filters.
  - BIN_WUP[k] (16-bit, Q0.16): weight on the rising slope of filter s (applies if s<NUM_FILTERS).
  - Falling weight 16'hFFFF-BIN_WUP[k] applies to filter s-1 (if s≥1).
  - Segments are non-decreasing in k.
- Two accumulators, acc_up and acc_dn, each 56 bits unsigned:
  - acc_up += P*WUP.
  - acc_dn += P*(FFFF-WUP).
  - Product is the full 48-bit unsigned product; no saturation is needed.
- On a segment change s→s': emit filter s-1 from acc_dn (if s≥1); acc_dn←acc_up; acc_up←0.
  - If s' > s+1, the skipped filters are emitted with energy 0.
- After the last bin: emit all filters not yet emitted.
- Filters that receive no bins emit 0.
- Every filter 0..NUM_FILTERS-1 is emitted exactly once, in strictly ascending order.
- Log encoder, one register stage:
  - X = acc>>16 (40-bit integer).
  - X==0 → 0.
  - Otherwise p = index of MSB of X (0..39). Energy = {p[5:0], next 3 bits below the MSB}, zero-filled when p<3.
- mel_valid is a one-cycle strobe per filter. The index and value are stable in that cycle.
- Back-to-back emissions are allowed.
- mel_done_o is asserted exactly one cycle after the final mel_valid, never in the same cycle.
- Latency: start to done ≤ NFFT + NUM_FILTERS + 4 cycles.
- A start pulse coincident with done is ignored. A new frame is accepted from IDLE only.
- Reset mid-frame aborts immediately. No partial done is produced.

Decomposition:
- Package mel_pkg:
  - constants NFFT_C, NUM_FILTERS_C, SEG_NONE=127;
  - tables BIN_SEG and BIN_WUP as localparam arrays;
  - typedefs for the accumulator (56 bits) and energy (9 bits).
- One sub-module mel_log2: combinational 40-bit → 9-bit log encoder (priority encoder plus mantissa select). It is unit-testable on its own.

Test Plan:
- Reset then idle: all outputs 0. Address stays 0 for 20 cycles with no start.
- All-zero frame, start pulse: 40 mel_valid strobes, indices 0..39 ascending, energies all 0. One done pulse, one cycle after the last valid.
- mel_log2 directed inputs:
  - X=1 → 0.
  - X=8 → 24.
  - X=12 → 28.
  - X=2^39 → 312.
  - X=2^40-1 → 319.
- Frame with every bin = 0xFFFFFFFF: energies match the golden model built from mel_pkg tables. No energy exceeds 319.
- Two frames back-to-back, with the second start 5 cycles after the first done: the second frame's results do not depend on the first (accumulators cleared).
- Start pulse mid-frame is ignored. Reset mid-frame: outputs return to 0 and no done pulse follows. The next start runs a full frame correctly.
